pb_io_hub: RTL and testbench

//  Parametrised I/O hub between the KCPSM6 core and the game logic.
//  - Decodes output ports into N_OUT registered output bytes plus single-cycle key-command pulses.
//  - Drives a registered in_port read mux.
//  - Contains an N_IRQ-source, edge-triggered, prioritised interrupt controller with mask,

---
 rtl/pb_io_hub_pkg.sv | 34 +++
 rtl/pb_io_hub_if.sv | 22 ++
 rtl/pb_io_hub_irq_ctrl.sv | 82 ++++++++
 rtl/pb_io_hub.sv | 119 +++++++++++
 tb/tb_pb_io_hub.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/pb_io_hub_pkg.sv
// Shared constants for the PicoBlaze I/O hub: IRQ register offsets,
// default key codes, the command-pulse bundle and the priority encoder.
package pb_io_pkg;

   // Offsets from IRQ_BASE
   localparam logic [7:0] IRQ_MASK_OFS = 8'h00;
   localparam logic [7:0] IRQ_PEND_OFS = 8'h01;
   localparam logic [7:0] IRQ_ID_OFS   = 8'h02;
   localparam logic [7:0] IRQ_EOI_OFS  = 8'h03;

   // Default key codes
   localparam logic [7:0] KEY_INC_DEF   = 8'h57;
   localparam logic [7:0] KEY_DEC_DEF   = 8'h53;
   localparam logic [7:0] KEY_LEFT_DEF  = 8'h65;
   localparam logic [7:0] KEY_RIGHT_DEF = 8'h68;

   // One-cycle command pulses decoded from the key port
   typedef struct packed {
      logic inc;
      logic dec;
      logic left;
      logic right;
   } key_cmd_t;

   // Lowest set bit -> index (0 = highest priority); returns 0 when empty
   function automatic logic [2:0] prio_enc(input logic [7:0] v);
      logic [2:0] idx;
      idx = '0;
      for (int i = 7; i >= 0; i--)
         if (v[i]) idx = 3'(i);
      return idx;
   endfunction

endpackage

// File: rtl/pb_io_hub_if.sv
// kcpsm6 port bus between the processor (master) and the I/O hub (slave).
// read_strobe is carried for completeness; the hub's reads are side-effect
// free, so the slave side does not consume it.
interface pb_io_hub_if;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       write_strobe;
   logic       read_strobe;
   logic [7:0] in_port;
   logic       interrupt;
   logic       interrupt_ack;

   modport master (
      output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
      input  in_port, interrupt
   );

   modport slave (
      input  port_id, out_port, write_strobe, interrupt_ack,
      output in_port, interrupt
   );
endinterface

// File: rtl/pb_io_hub_irq_ctrl.sv
// Edge-triggered, prioritised interrupt controller with mask, pending,
// in-service ID and EOI. Index 0 is the highest priority. No nesting:
// a new request is held off while a source is in service.
module pb_irq_ctrl
   import pb_io_pkg::*;
#(
   parameter int N_IRQ = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq_src,
   input  logic             ack,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wdata,
   input  logic             eoi_we,
   output logic [N_IRQ-1:0] mask,
   output logic [N_IRQ-1:0] pending,
   output logic [2:0]       id,
   output logic             irq_active,
   output logic             interrupt
);

   logic [N_IRQ-1:0] prev;
   logic [N_IRQ-1:0] edges;
   logic [N_IRQ-1:0] req;
   logic [N_IRQ-1:0] clr;
   logic [7:0]       req8;
   logic [2:0]       sel;
   logic             take;

   // Edge detect, winner selection (pre-edge mask) and the bit to retire
   always_comb begin
      edges = irq_src & ~prev;
      req   = pending & mask;
      req8  = '0;
      req8[N_IRQ-1:0] = req;
      sel   = prio_enc(req8);
      take  = ack & (|req);
      clr   = '0;
      for (int k = 0; k < N_IRQ; k++)
         clr[k] = take && (sel == 3'(k));
   end

   // Previous source levels; resetting to 0 makes a held-high line one edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev <= '0;
      else       prev <= irq_src;
   end

   // Pending latch: a fresh edge beats the ack that retires the same bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pending <= '0;
      else       pending <= (pending & ~clr) | edges;
   end

   // Mask register, all sources enabled out of reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        mask <= '1;
      else if (mask_we) mask <= mask_wdata;
   end

   // In-service tracking; an ack in the same cycle as EOI wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id         <= '0;
         irq_active <= 1'b0;
      end else if (take) begin
         id         <= sel;
         irq_active <= 1'b1;
      end else if (eoi_we) begin
         irq_active <= 1'b0;
      end
   end

   // Registered request level to the core, dropped on the accepting ack
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     interrupt <= 1'b0;
      else if (take) interrupt <= 1'b0;
      else           interrupt <= (|req) & ~irq_active;
   end

endmodule

// File: rtl/pb_io_hub.sv
// I/O hub beside kcpsm6: output byte registers, key-command pulses,
// registered in_port read mux and the interrupt controller.
module pb_io_hub
   import pb_io_pkg::*;
#(
   parameter int         N_OUT     = 4,
   parameter int         N_IRQ     = 4,
   parameter logic [7:0] KEY_PORT  = 8'h01,
   parameter logic [7:0] OUT_BASE  = 8'h02,
   parameter logic [7:0] IRQ_BASE  = 8'h10,
   parameter logic [7:0] KEY_INC   = KEY_INC_DEF,
   parameter logic [7:0] KEY_DEC   = KEY_DEC_DEF,
   parameter logic [7:0] KEY_LEFT  = KEY_LEFT_DEF,
   parameter logic [7:0] KEY_RIGHT = KEY_RIGHT_DEF
) (
   input  logic               clk,
   input  logic               reset,
   pb_io_hub_if.slave         bus,
   input  logic [7:0]         ext_in,
   input  logic [N_IRQ-1:0]   irq_src,
   output logic [8*N_OUT-1:0] out_regs,
   output logic               cmd_inc,
   output logic               cmd_dec,
   output logic               cmd_left,
   output logic               cmd_right,
   output logic               irq_active
);

   localparam logic [7:0] MASK_PORT = IRQ_BASE + IRQ_MASK_OFS;
   localparam logic [7:0] PEND_PORT = IRQ_BASE + IRQ_PEND_OFS;
   localparam logic [7:0] ID_PORT   = IRQ_BASE + IRQ_ID_OFS;
   localparam logic [7:0] EOI_PORT  = IRQ_BASE + IRQ_EOI_OFS;

   logic [N_OUT-1:0][7:0] regs_q;
   key_cmd_t              cmd_q;
   logic [7:0]            rd_data;
   logic [7:0]            in_port_q;
   logic [7:0]            mask8;
   logic [7:0]            pend8;
   logic [N_IRQ-1:0]      mask;
   logic [N_IRQ-1:0]      pending;
   logic [2:0]            id;
   logic                  irq_req;
   logic                  key_we;
   logic                  mask_we;
   logic                  eoi_we;

   assign key_we  = bus.write_strobe && (bus.port_id == KEY_PORT);
   assign mask_we = bus.write_strobe && (bus.port_id == MASK_PORT);
   assign eoi_we  = bus.write_strobe && (bus.port_id == EOI_PORT);

   // Output byte registers, one per consecutive port from OUT_BASE
   for (genvar i = 0; i < N_OUT; i++) begin : g_out
      localparam logic [7:0] PORT = OUT_BASE + 8'(i);
      // Byte i captures out_port on a strobe to its own port
      always_ff @(posedge clk or posedge reset) begin
         if (reset)
            regs_q[i] <= '0;
         else if (bus.write_strobe && (bus.port_id == PORT))
            regs_q[i] <= bus.out_port;
      end
   end
   assign out_regs = regs_q;

   // Key codes become single-cycle pulses the cycle after the strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_q <= '0;
      end else begin
         cmd_q.inc   <= key_we && (bus.out_port == KEY_INC);
         cmd_q.dec   <= key_we && (bus.out_port == KEY_DEC);
         cmd_q.left  <= key_we && (bus.out_port == KEY_LEFT);
         cmd_q.right <= key_we && (bus.out_port == KEY_RIGHT);
      end
   end
   assign cmd_inc   = cmd_q.inc;
   assign cmd_dec   = cmd_q.dec;
   assign cmd_left  = cmd_q.left;
   assign cmd_right = cmd_q.right;

   pb_irq_ctrl #(.N_IRQ(N_IRQ)) u_irq (
      .clk        (clk),
      .reset      (reset),
      .irq_src    (irq_src),
      .ack        (bus.interrupt_ack),
      .mask_we    (mask_we),
      .mask_wdata (bus.out_port[N_IRQ-1:0]),
      .eoi_we     (eoi_we),
      .mask       (mask),
      .pending    (pending),
      .id         (id),
      .irq_active (irq_active),
      .interrupt  (irq_req)
   );

   // Read mux; unmapped ports fall through to ext_in, narrow regs zero-extend
   always_comb begin
      mask8 = '0;
      mask8[N_IRQ-1:0] = mask;
      pend8 = '0;
      pend8[N_IRQ-1:0] = pending;
      rd_data = ext_in;
      if (bus.port_id == MASK_PORT) rd_data = mask8;
      if (bus.port_id == PEND_PORT) rd_data = pend8;
      if (bus.port_id == ID_PORT)   rd_data = {irq_active, 4'b0000, id};
      for (int i = 0; i < N_OUT; i++)
         if (bus.port_id == OUT_BASE + 8'(i)) rd_data = regs_q[i];
   end

   // Registered read data, ready one cycle after port_id settles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) in_port_q <= '0;
      else       in_port_q <= rd_data;
   end

   assign bus.in_port   = in_port_q;
   assign bus.interrupt = irq_req;

endmodule

// File: tb/tb_pb_io_hub.sv
// Directed bench for pb_io_hub: output regs, key pulses, read mux, IRQ flow.
module tb_pb_io_hub;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  ext_in;
   logic [3:0]  irq_src;
   logic [31:0] out_regs;
   logic        cmd_inc, cmd_dec, cmd_left, cmd_right;
   logic        irq_active;
   logic [3:0]  cmd_v;

   int errs   = 0;
   int checks = 0;

   pb_io_hub_if bus ();

   pb_io_hub dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .ext_in     (ext_in),
      .irq_src    (irq_src),
      .out_regs   (out_regs),
      .cmd_inc    (cmd_inc),
      .cmd_dec    (cmd_dec),
      .cmd_left   (cmd_left),
      .cmd_right  (cmd_right),
      .irq_active (irq_active)
   );

   assign cmd_v = {cmd_inc, cmd_dec, cmd_left, cmd_right};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] p, input logic [7:0] d);
      bus.port_id      = p;
      bus.out_port     = d;
      bus.write_strobe = 1'b1;
      tick();
      bus.write_strobe = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [7:0] p, input logic [7:0] exp);
      bus.port_id = p;
      tick();
      chk(tag, bus.in_port, exp);
   endtask

   task automatic ack();
      bus.interrupt_ack = 1'b1;
      tick();
      bus.interrupt_ack = 1'b0;
   endtask

   initial begin
      reset             = 1'b1;
      ext_in            = 8'h3C;
      irq_src           = '0;
      bus.port_id       = '0;
      bus.out_port      = '0;
      bus.write_strobe  = 1'b0;
      bus.read_strobe   = 1'b0;
      bus.interrupt_ack = 1'b0;
      tick();
      chk("rst_out_regs", out_regs, 32'h0);
      chk("rst_in_port", bus.in_port, 8'h00);
      chk("rst_irq", {bus.interrupt, irq_active}, 2'b00);
      chk("rst_cmd", cmd_v, 4'h0);
      reset = 1'b0;

      // 1: output byte write and readback
      wr(8'h03, 8'hA5);
      chk("out_byte1", out_regs, 32'h0000_A500);
      rd("rd_out1", 8'h03, 8'hA5);
      rd("rd_ext", 8'h07, 8'h3C);
      rd("rd_mask_def", 8'h10, 8'h0F);
      rd("rd_eoi_is_ext", 8'h13, 8'h3C);

      // 2: key command pulses
      wr(8'h01, 8'h57);
      chk("inc_pulse", cmd_v, 4'b1000);
      tick();
      chk("inc_gone", cmd_v, 4'b0000);
      wr(8'h01, 8'h68);
      chk("right_pulse", cmd_v, 4'b0001);
      tick();
      chk("right_gone", cmd_v, 4'b0000);
      wr(8'h01, 8'h00);
      chk("no_pulse0", cmd_v, 4'b0000);
      tick();
      chk("no_pulse1", cmd_v, 4'b0000);

      // 3: two simultaneous sources, priority and EOI re-raise
      irq_src = 4'b0110;
      tick();
      irq_src = 4'b0000;
      chk("irq_not_yet", bus.interrupt, 1'b0);
      tick();
      chk("irq_rise", bus.interrupt, 1'b1);
      ack();
      chk("ack_drop", {bus.interrupt, irq_active}, 2'b01);
      rd("id_1", 8'h12, 8'h81);
      rd("pend_0100", 8'h11, 8'h04);
      chk("no_nest", bus.interrupt, 1'b0);
      wr(8'h13, 8'h00);
      chk("eoi_clear", irq_active, 1'b0);
      tick();
      chk("irq_rerise", bus.interrupt, 1'b1);
      ack();
      rd("id_2", 8'h12, 8'h82);
      rd("pend_empty", 8'h11, 8'h00);
      wr(8'h13, 8'h00);
      tick();
      chk("idle_irq", bus.interrupt, 1'b0);

      // 4: masked source still latches pending
      wr(8'h10, 8'h0E);
      irq_src = 4'b0001;
      tick();
      irq_src = 4'b0000;
      tick();
      tick();
      chk("masked_low", bus.interrupt, 1'b0);
      rd("pend_masked", 8'h11, 8'h01);
      wr(8'h10, 8'h0F);
      chk("unmask_lag", bus.interrupt, 1'b0);
      tick();
      chk("unmask_rise", bus.interrupt, 1'b1);
      ack();
      rd("id_0", 8'h12, 8'h80);
      wr(8'h13, 8'h00);
      tick();

      // 5: new src2 edge coincident with the ack clearing bit 2
      irq_src = 4'b0100;
      tick();
      irq_src = 4'b0000;
      tick();
      chk("src2_irq", bus.interrupt, 1'b1);
      irq_src = 4'b0100;
      bus.interrupt_ack = 1'b1;
      tick();
      bus.interrupt_ack = 1'b0;
      irq_src = 4'b0000;
      chk("coinc_active", irq_active, 1'b1);
      rd("coinc_id", 8'h12, 8'h82);
      rd("coinc_pend", 8'h11, 8'h04);
      // ack and EOI together: ack wins
      bus.port_id = 8'h13;
      bus.write_strobe = 1'b1;
      bus.interrupt_ack = 1'b1;
      tick();
      bus.write_strobe = 1'b0;
      bus.interrupt_ack = 1'b0;
      chk("ack_beats_eoi", irq_active, 1'b1);
      rd("pend_after_both", 8'h11, 8'h00);

      // 6: reset mid-service
      irq_src = 4'b0101;
      tick();
      irq_src = 4'b0001;
      rd("pend_0101", 8'h11, 8'h05);
      chk("svc_state", {bus.interrupt, irq_active}, 2'b01);
      #2 reset = 1'b1;
      #1;
      chk("arst_out_regs", out_regs, 32'h0);
      chk("arst_in_port", bus.in_port, 8'h00);
      chk("arst_irq", {bus.interrupt, irq_active}, 2'b00);
      tick();
      bus.port_id = 8'h10;
      reset = 1'b0;
      tick();
      chk("post_rst_mask", bus.in_port, 8'h0F);
      chk("post_rst_irq0", bus.interrupt, 1'b0);
      tick();
      chk("post_rst_irq1", bus.interrupt, 1'b1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
